// File: rtl/param_updown_counter_pkg.sv
// Shared definitions for the parametrised up/down counter: direction and mode
// encodings, limit-event type and small elaboration-time helper functions.
package param_updown_counter_pkg;

  // Direction encoding on the d input
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Behaviour at the count limits (SATURATE parameter values)
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Which limit, if any, a step ran into this cycle
  typedef enum logic [1:0] {
    EV_NONE = 2'd0,
    EV_OVF  = 2'd1,
    EV_UDF  = 2'd2
  } limit_ev_e;

  // Count range must hold at least two values and fit in the register
  function automatic bit modulo_ok(input int width, input longint modulo);
    longint full;
    full = longint'(1) << width;
    return (modulo >= 2) && (modulo <= full);
  endfunction

  // Prescaler counter width; a one-bit register is the floor
  function automatic int presc_width(input int prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/param_updown_counter_if.sv
// Control/status bundle between a counter user (master) and the counter (slave).
interface param_updown_counter_if #(
  parameter int WIDTH = 3
) ();

  logic             en;
  logic             d;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             clr_flags;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             ovf;
  logic             udf;

  // Side that issues commands and watches the count
  modport master (
    output en, d, load, load_val, clr_flags,
    input  q, tc, ovf, udf
  );

  // The counter itself
  modport slave (
    input  en, d, load, load_val, clr_flags,
    output q, tc, ovf, udf
  );

endinterface

// File: rtl/param_updown_counter_tick_prescaler.sv
// Divides enabled cycles by PRESCALE: tick is high on every PRESCALE-th enabled
// cycle. The count only moves while en=1, and restart returns it to zero so the
// next tick is a full PRESCALE enabled cycles away.
module tick_prescaler
  import param_updown_counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic tick
);

  generate
    if (PRESCALE == 1) begin : g_bypass
      // No division: every enabled cycle is a tick
      logic unused_inputs;
      assign unused_inputs = ^{clk, rst, restart};
      assign tick = en;
    end else begin : g_divide
      localparam int              CW   = presc_width(PRESCALE);
      localparam logic [CW-1:0]   LAST = CW'(PRESCALE - 1);

      logic [CW-1:0] cnt_reg;

      // Phase counter: clears on reset/restart, wraps at LAST while enabled
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg <= '0;
        end else if (restart) begin
          cnt_reg <= '0;
        end else if (en) begin
          cnt_reg <= (cnt_reg == LAST) ? '0 : cnt_reg + CW'(1);
        end
      end

      // Tick is qualified by en so a held prescaler never fires
      assign tick = en && (cnt_reg == LAST);
    end
  endgenerate

endmodule

// File: rtl/param_updown_counter.sv
// Parametrised synchronous up/down counter with modulo range, wrap or saturate
// behaviour, prescaled enable, parallel load, terminal-count pulse and sticky
// overflow/underflow flags. All outputs come straight from registers.
module param_updown_counter
  import param_updown_counter_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter int MODULO   = 2 ** WIDTH,
  parameter int SATURATE = MODE_WRAP,
  parameter int PRESCALE = 1
) (
  input logic                          clk,
  input logic                          rst,
  param_updown_counter_if.slave        bus
);

  // Reject configurations that cannot be built
  generate
    if (WIDTH < 1) begin : g_bad_width
      $error("param_updown_counter: WIDTH must be >= 1");
    end
    if (!modulo_ok(WIDTH, longint'(MODULO))) begin : g_bad_modulo
      $error("param_updown_counter: MODULO must be in 2..2**WIDTH");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
      $error("param_updown_counter: PRESCALE must be >= 1");
    end
    if ((SATURATE != MODE_WRAP) && (SATURATE != MODE_SAT)) begin : g_bad_mode
      $error("param_updown_counter: SATURATE must be 0 or 1");
    end
  endgenerate

  // Highest legal count; compares use this, not the natural register rollover
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULO - 1);

  logic [WIDTH-1:0] q_reg, q_next;
  logic             tc_reg, tc_next;
  logic             ovf_reg, ovf_next;
  logic             udf_reg, udf_next;
  logic             step;
  logic [WIDTH-1:0] load_clamped;
  limit_ev_e        limit_ev;

  // A load realigns the prescaler so the next step is a full period later
  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .en      (bus.en),
    .restart (bus.load),
    .tick    (step)
  );

  // Out-of-range load values are pinned to the top of the range
  assign load_clamped = (bus.load_val > MAX_Q) ? MAX_Q : bus.load_val;

  // Next-state: load beats step; limit hits raise tc and the matching flag
  always_comb begin
    q_next   = q_reg;
    tc_next  = 1'b0;
    limit_ev = EV_NONE;

    if (bus.load) begin
      q_next = load_clamped;
    end else if (step) begin
      if (bus.d == DIR_UP) begin
        if (q_reg == MAX_Q) begin
          limit_ev = EV_OVF;
          tc_next  = 1'b1;
          if (SATURATE == MODE_WRAP) begin
            q_next = '0;
          end
        end else begin
          q_next = q_reg + WIDTH'(1);
        end
      end else begin
        if (q_reg == '0) begin
          limit_ev = EV_UDF;
          tc_next  = 1'b1;
          if (SATURATE == MODE_WRAP) begin
            q_next = MAX_Q;
          end
        end else begin
          q_next = q_reg - WIDTH'(1);
        end
      end
    end

    // A fresh event in the clearing cycle keeps the flag set
    ovf_next = (ovf_reg && !bus.clr_flags) || (limit_ev == EV_OVF);
    udf_next = (udf_reg && !bus.clr_flags) || (limit_ev == EV_UDF);
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg   <= '0;
      tc_reg  <= 1'b0;
      ovf_reg <= 1'b0;
      udf_reg <= 1'b0;
    end else begin
      q_reg   <= q_next;
      tc_reg  <= tc_next;
      ovf_reg <= ovf_next;
      udf_reg <= udf_next;
    end
  end

  assign bus.q   = q_reg;
  assign bus.tc  = tc_reg;
  assign bus.ovf = ovf_reg;
  assign bus.udf = udf_reg;

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench for param_updown_counter across four configurations:
//   A: WIDTH=3 wrap, B: WIDTH=3 saturate, C: WIDTH=4 MODULO=10 wrap,
//   D: WIDTH=3 wrap with PRESCALE=3.
module tb_param_updown_counter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  param_updown_counter_if #(.WIDTH(3)) ia ();
  param_updown_counter_if #(.WIDTH(3)) ib ();
  param_updown_counter_if #(.WIDTH(4)) ic ();
  param_updown_counter_if #(.WIDTH(3)) id ();

  param_updown_counter #(.WIDTH(3), .MODULO(8), .SATURATE(0), .PRESCALE(1))
    dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
  param_updown_counter #(.WIDTH(3), .MODULO(8), .SATURATE(1), .PRESCALE(1))
    dut_b (.clk(clk), .rst(rst), .bus(ib.slave));
  param_updown_counter #(.WIDTH(4), .MODULO(10), .SATURATE(0), .PRESCALE(1))
    dut_c (.clk(clk), .rst(rst), .bus(ic.slave));
  param_updown_counter #(.WIDTH(3), .MODULO(8), .SATURATE(0), .PRESCALE(3))
    dut_d (.clk(clk), .rst(rst), .bus(id.slave));

  // One comparison: count it, report a mismatch
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    ia.en = 0; ia.d = 0; ia.load = 0; ia.load_val = '0; ia.clr_flags = 0;
    ib.en = 0; ib.d = 0; ib.load = 0; ib.load_val = '0; ib.clr_flags = 0;
    ic.en = 0; ic.d = 0; ic.load = 0; ic.load_val = '0; ic.clr_flags = 0;
    id.en = 0; id.d = 0; id.load = 0; id.load_val = '0; id.clr_flags = 0;

    // Reset state
    rst = 1; cyc(); cyc(); rst = 0;
    chk("rst_a_q", 32'(ia.q), 0);
    chk("rst_a_tc", 32'(ia.tc), 0);
    chk("rst_a_ovf", 32'(ia.ovf), 0);
    chk("rst_a_udf", 32'(ia.udf), 0);
    chk("rst_c_q", 32'(ic.q), 0);

    // 1: up-count wrap on A, nine steps: 1..7,0,1
    ia.en = 1; ia.d = 1;
    for (int i = 1; i <= 9; i++) begin
      cyc();
      chk($sformatf("t1_q_%0d", i), 32'(ia.q), 32'(i % 8));
      chk($sformatf("t1_tc_%0d", i), 32'(ia.tc), (i == 8) ? 32'd1 : 32'd0);
    end
    chk("t1_ovf", 32'(ia.ovf), 1);
    chk("t1_udf", 32'(ia.udf), 0);
    // down through zero wraps to 7
    ia.d = 0;
    cyc(); chk("t1_dn_q0", 32'(ia.q), 0); chk("t1_dn_tc0", 32'(ia.tc), 0);
    cyc(); chk("t1_dn_q7", 32'(ia.q), 7); chk("t1_dn_tc7", 32'(ia.tc), 1);
    chk("t1_dn_udf", 32'(ia.udf), 1);
    ia.en = 0; ia.clr_flags = 1;
    cyc(); ia.clr_flags = 0;
    chk("t1_clr_ovf", 32'(ia.ovf), 0);
    chk("t1_clr_udf", 32'(ia.udf), 0);
    chk("t1_clr_q", 32'(ia.q), 7);
    chk("t1_clr_tc", 32'(ia.tc), 0);

    // 2: saturate at zero on B, tc every attempted step
    ib.en = 1; ib.d = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("t2_q_%0d", i), 32'(ib.q), 0);
      chk($sformatf("t2_tc_%0d", i), 32'(ib.tc), 1);
    end
    chk("t2_udf", 32'(ib.udf), 1);
    ib.en = 0;
    cyc(); chk("t2_tc_idle", 32'(ib.tc), 0);
    ib.clr_flags = 1;
    cyc(); ib.clr_flags = 0;
    chk("t2_clr_udf", 32'(ib.udf), 0);
    // saturate at top
    ib.load = 1; ib.load_val = 3'd7;
    cyc(); ib.load = 0;
    chk("t2_load7", 32'(ib.q), 7);
    ib.en = 1; ib.d = 1;
    cyc(); ib.en = 0;
    chk("t2_sat_q", 32'(ib.q), 7);
    chk("t2_sat_tc", 32'(ib.tc), 1);
    chk("t2_sat_ovf", 32'(ib.ovf), 1);

    // 3: MODULO=10 on C
    ic.load = 1; ic.load_val = 4'd12;
    cyc();
    chk("t3_clamp", 32'(ic.q), 9);
    chk("t3_clamp_tc", 32'(ic.tc), 0);
    ic.load_val = 4'd4;
    cyc(); chk("t3_load4", 32'(ic.q), 4);
    ic.load_val = 4'd9;
    cyc(); ic.load = 0;
    chk("t3_load9", 32'(ic.q), 9);
    ic.en = 1; ic.d = 1;
    cyc(); chk("t3_wrap_q", 32'(ic.q), 0); chk("t3_wrap_tc", 32'(ic.tc), 1);
    chk("t3_ovf", 32'(ic.ovf), 1);
    ic.d = 0;
    cyc(); chk("t3_dn_q", 32'(ic.q), 9); chk("t3_dn_tc", 32'(ic.tc), 1);
    chk("t3_udf", 32'(ic.udf), 1);
    cyc(); chk("t3_dn8", 32'(ic.q), 8); chk("t3_dn8_tc", 32'(ic.tc), 0);
    ic.en = 0;

    // 4: PRESCALE=3 on D
    id.en = 1; id.d = 1;
    for (int i = 1; i <= 6; i++) begin
      cyc();
      chk($sformatf("t4_q_%0d", i), 32'(id.q), 32'(i / 3));
    end
    cyc(); chk("t4_q_7", 32'(id.q), 2);
    id.en = 0;
    cyc(); cyc(); chk("t4_hold", 32'(id.q), 2);
    id.en = 1;
    cyc(); chk("t4_resume1", 32'(id.q), 2);
    cyc(); chk("t4_resume2", 32'(id.q), 3);
    cyc(); chk("t4_pre_load", 32'(id.q), 3);
    id.load = 1; id.load_val = 3'd5;
    cyc(); id.load = 0;
    chk("t4_load", 32'(id.q), 5);
    cyc(); chk("t4_after_load1", 32'(id.q), 5);
    cyc(); chk("t4_after_load2", 32'(id.q), 5);
    cyc(); chk("t4_after_load3", 32'(id.q), 6);

    // 5: simultaneous events on A (q=7, flags clear)
    ia.load = 1; ia.load_val = 3'd3; ia.en = 1; ia.d = 1;
    cyc(); ia.load = 0; ia.en = 0;
    chk("t5_load_wins", 32'(ia.q), 3);
    chk("t5_load_tc", 32'(ia.tc), 0);
    ia.load = 1; ia.load_val = 3'd7;
    cyc(); ia.load = 0;
    ia.en = 1; ia.clr_flags = 1;
    cyc(); ia.en = 0;
    chk("t5_set_wins_ovf", 32'(ia.ovf), 1);
    chk("t5_set_wins_q", 32'(ia.q), 0);
    cyc(); ia.clr_flags = 0;
    chk("t5_clr_after", 32'(ia.ovf), 0);

    // 6: reset mid-count (A) and mid-prescale (D)
    ia.load = 1; ia.load_val = 3'd7;
    cyc(); ia.load = 0; ia.en = 1;
    cyc();
    chk("t6_pre_ovf", 32'(ia.ovf), 1);
    chk("t6_pre_tc", 32'(ia.tc), 1);
    // D: one enabled cycle leaves the prescaler part-way
    rst = 1; ia.load = 1; ia.load_val = 3'd5;
    cyc();
    rst = 0; ia.load = 0;
    chk("t6_rst_q", 32'(ia.q), 0);
    chk("t6_rst_tc", 32'(ia.tc), 0);
    chk("t6_rst_ovf", 32'(ia.ovf), 0);
    chk("t6_rst_udf", 32'(ia.udf), 0);
    chk("t6_rst_dq", 32'(id.q), 0);
    cyc();
    chk("t6_resume_a", 32'(ia.q), 1);
    chk("t6_resume_tc", 32'(ia.tc), 0);
    chk("t6_d_1", 32'(id.q), 0);
    cyc(); chk("t6_d_2", 32'(id.q), 0);
    cyc(); chk("t6_d_3", 32'(id.q), 1);
    ia.en = 0; id.en = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
